// File: rtl/uart_rx_if.sv
// uart_rx_if: machine-bus slot used by the cpu to talk to the UART receiver.
//   addr     2  register select (0 DATA, 1 STATUS, 2 COUNT, 3 reserved)
//   rd_en    1  single-cycle read strobe
//   rd_data  8  registered read data
//   rd_valid 1  one-cycle pulse, the cycle after rd_en
//   wr_en    1  single-cycle write strobe
//   wr_data  8  write data (only STATUS is writable)
// master = cpu side, slave = uart_rx side.
interface uart_rx_if;
    logic [1:0] addr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       wr_en;
    logic [7:0] wr_data;

    modport master (
        output addr, rd_en, wr_en, wr_data,
        input  rd_data, rd_valid
    );

    modport slave (
        input  addr, rd_en, wr_en, wr_data,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: bus-mapped 8N1 UART receiver with a receive FIFO.
//   clk    in  system clock, all logic on posedge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of uart_rx_if (addr/rd_en/rd_data/rd_valid/wr_en/wr_data)
//   rx     in  asynchronous serial line, idle high
// Registers: DATA (pop head), STATUS {frame_err, overrun, full, !empty},
// COUNT (occupancy). Writing STATUS with bit2/bit3 set clears overrun/frame_err.
module uart_rx #(
    parameter int DIV        = 104,
    parameter int FIFO_DEPTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus,
    input  logic      rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ------------------------------------------------------------------
    // Input synchronizer plus one extra stage for falling-edge detection
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_s_q, rx_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM. push_q/frame_set_q are one-cycle strobes consumed by
    // the FIFO/flag logic in the following cycle.
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        push_q;
    logic [7:0]  push_data_q;
    logic        frame_set_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_set_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_set_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // Only a genuine 1->0 transition starts a frame, so a
                    // line that stays low never retriggers.
                    if (!rx_s_q && rx_prev_q) begin
                        state_q <= S_START;
                        cnt_q   <= HALF_M1;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        if (!rx_s_q) begin
                            state_q <= S_DATA;
                            cnt_q   <= FULL_M1;
                            bit_q   <= '0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        cnt_q   <= FULL_M1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                        bit_q <= bit_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        if (rx_s_q) begin
                            push_q      <= 1'b1;
                            push_data_q <= shift_q;
                        end else begin
                            frame_set_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: plain array, no reset, so it maps onto RAM.
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q;

    logic fifo_full, fifo_empty, pop, push_ok, ovr_set;
    logic clr_ovr, clr_ferr, status_wr;

    always_comb begin
        fifo_full  = (count_q == CW'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        pop        = bus.rd_en && (bus.addr == 2'd0) && !fifo_empty;
        // A same-cycle pop frees the slot, so a push into a full FIFO is
        // still accepted in that case.
        push_ok    = push_q && (!fifo_full || pop);
        ovr_set    = push_q && fifo_full && !pop;

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);

        status_wr = bus.wr_en && (bus.addr == 2'd1);
        clr_ovr   = status_wr && bus.wr_data[2];
        clr_ferr  = status_wr && bus.wr_data[3];
        // Set has priority over a simultaneous clear.
        overrun_d   = ovr_set     | (overrun_q   & ~clr_ovr);
        frame_err_d = frame_set_q | (frame_err_q & ~clr_ferr);

        rd_data_d = '0;
        case (bus.addr)
            2'd0: rd_data_d = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
            2'd1: rd_data_d = {4'b0000, frame_err_q, overrun_q, fifo_full, !fifo_empty};
            2'd2: rd_data_d = 8'(count_q);
            default: rd_data_d = 8'h00;
        endcase
    end

    // Read-before-write on the same address: when full with push+pop, the
    // pop still sees the old head because mem_q updates at the same edge.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rd_valid_q  <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    // Only bits 2 and 3 of a STATUS write carry meaning.
    logic unused_wr_bits;
    assign unused_wr_bits = ^{bus.wr_data[7:4], bus.wr_data[1:0]};

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    localparam int DIV   = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;

    uart_rx_if bus();

    uart_rx #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .rx    (rx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: the FIFO contents as a queue, plus the two flags.
    logic [7:0] model_q[$];
    logic       m_ovr  = 1'b0;
    logic       m_ferr = 1'b0;

    // Expectation handed from the read task to the compare process.
    logic       pend_v = 1'b0;
    logic [7:0] pend_d = 8'h00;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Compare process: every cycle, rd_valid must equal "a read was issued
    // before this edge", and the data must match the model's answer.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            total++;
            if (bus.rd_valid !== pend_v) begin
                bad++;
                $display("FAIL rd_valid: got=%0b expected=%0b at %0t", bus.rd_valid, pend_v, $time);
            end
            if (pend_v) begin
                total++;
                if (bus.rd_data !== pend_d) begin
                    bad++;
                    $display("FAIL rd_data: got=%02h expected=%02h at %0t", bus.rd_data, pend_d, $time);
                end
            end
            pend_v = 1'b0;
        end
    end

    function automatic logic [7:0] model_read(input logic [1:0] a);
        logic [7:0] e;
        case (a)
            2'd0: e = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
            2'd1: e = {4'b0000, m_ferr, m_ovr, (model_q.size() == DEPTH), (model_q.size() != 0)};
            2'd2: e = 8'(model_q.size());
            default: e = 8'h00;
        endcase
        return e;
    endfunction

    task automatic do_read(input logic [1:0] a, output logic [7:0] d);
        logic [7:0] e;
        @(negedge clk);
        e           = model_read(a);
        bus.addr    = a;
        bus.rd_en   = 1'b1;
        pend_d      = e;
        pend_v      = 1'b1;
        @(posedge clk);
        #1;
        d         = bus.rd_data;
        bus.rd_en = 1'b0;
        $display("read  addr=%0d data=%02h model=%02h", a, d, e);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        bus.addr    = a;
        bus.wr_data = v;
        bus.wr_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        if (a == 2'd1) begin
            if (v[2]) m_ovr  = 1'b0;
            if (v[3]) m_ferr = 1'b0;
        end
        $display("write addr=%0d data=%02h", a, v);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    // One complete 8N1 frame; the model is updated once the frame is over.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        if (stop) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        $display("send  byte=%02h stop=%0b", b, stop);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    logic [7:0] d;

    initial begin
        bus.addr    = 2'd0;
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_rd_data", int'(bus.rd_data), 0);
        check("reset_rd_valid", int'(bus.rd_valid), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_read(2'd1, d); check("reset_status", d, 8'h00);
        do_read(2'd2, d); check("reset_count", d, 8'h00);

        // 1: two bytes, read back in order
        send_byte(8'h55, 1'b1);
        send_byte(8'hA3, 1'b1);
        do_read(2'd0, d); check("t1_data0", d, 8'h55);
        do_read(2'd0, d); check("t1_data1", d, 8'hA3);
        do_read(2'd1, d); check("t1_status", d, 8'h00);

        // 2: overflow by one
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
        do_read(2'd1, d); check("t2_status", d, 8'h07);
        do_read(2'd2, d); check("t2_count", d, 8'd16);
        for (int i = 0; i < 16; i++) begin
            do_read(2'd0, d); check("t2_data", d, i);
        end
        do_read(2'd0, d); check("t2_empty_read", d, 8'h00);
        do_read(2'd2, d); check("t2_count_after", d, 8'd0);
        do_write(2'd1, 8'h04);
        do_read(2'd1, d); check("t2_ovr_clear", d, 8'h00);

        // 3: framing error and its clear
        send_byte(8'h3C, 1'b0);
        do_read(2'd1, d); check("t3_status", d, 8'h08);
        do_read(2'd2, d); check("t3_count", d, 8'd0);
        do_write(2'd1, 8'h08);
        do_read(2'd1, d); check("t3_cleared", d, 8'h00);

        // 4: short low glitch must not produce a byte
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        do_read(2'd2, d); check("t4_count", d, 8'd0);
        do_read(2'd1, d); check("t4_status", d, 8'h00);
        send_byte(8'h96, 1'b1);
        do_read(2'd0, d); check("t4_idle_ok", d, 8'h96);

        // 5: reset in the middle of data bit 3
        @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        do_read(2'd2, d); check("t5_count_reset", d, 8'd0);
        send_byte(8'hE1, 1'b1);
        do_read(2'd2, d); check("t5_count", d, 8'd1);
        do_read(2'd0, d); check("t5_data", d, 8'hE1);

        // 6: DATA read swept across the STOP push of 0x7E with one byte held
        for (int off = 148; off <= 162; off++) begin
            send_byte(8'h5A, 1'b1);
            fork
                send_byte(8'h7E, 1'b1);
                begin
                    repeat (off) @(negedge clk);
                    do_read(2'd0, d);
                    check("t6_old_head", d, 8'h5A);
                end
            join
            do_read(2'd2, d); check("t6_count", d, 8'd1);
            do_read(2'd0, d); check("t6_new", d, 8'h7E);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0, 1: send_byte(8'($urandom), ($urandom_range(0, 7) != 0));
                2:    do_read(2'($urandom), d);
                default: do_write(2'($urandom), 8'($urandom));
            endcase
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        while (model_q.size() > 0) do_read(2'd0, d);
        do_read(2'd1, d);
        do_read(2'd2, d);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #5000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
